// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the RV32M divide sequencer: funct3 encodings,
// FSM state type and operation decode helpers.
package div_sequencer_pkg;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Codes outside the M-extension divide group fall through as DIVU.
  function automatic logic op_is_signed(input logic [2:0] f3);
    return (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
  endfunction

  function automatic logic op_is_rem(input logic [2:0] f3);
    return (f3 == FUNCT3_REM) || (f3 == FUNCT3_REMU);
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response bundle between the execute stage and the divide sequencer.
interface div_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            kill_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, funct3_i, rs1_i, rs2_i, kill_i,
    input  busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, funct3_i, rs1_i, rs2_i, kill_i,
    output busy_o, valid_o, result_o
  );
endinterface

// File: rtl/div_operand_prep.sv
// Combinational operand conditioning: magnitudes, result sign flags and
// divide-by-zero / signed-overflow detection for one divide request.
module div_operand_prep
  import div_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            is_rem_o,
  output logic [XLEN-1:0] dvd_mag_o,
  output logic [XLEN-1:0] dvs_mag_o,
  output logic            neg_quo_o,
  output logic            neg_rem_o,
  output logic            div_zero_o,
  output logic            overflow_o
);

  localparam logic [XLEN-1:0] ONE     = XLEN'(1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] v);
    return ~v + ONE;
  endfunction

  logic is_signed;
  logic rs1_neg;
  logic rs2_neg;

  always_comb begin
    is_signed  = op_is_signed(funct3_i);
    is_rem_o   = op_is_rem(funct3_i);
    rs1_neg    = is_signed & rs1_i[XLEN-1];
    rs2_neg    = is_signed & rs2_i[XLEN-1];
    dvd_mag_o  = rs1_neg ? neg2c(rs1_i) : rs1_i;
    dvs_mag_o  = rs2_neg ? neg2c(rs2_i) : rs2_i;
    neg_quo_o  = rs1_neg ^ rs2_neg;
    neg_rem_o  = rs1_neg;
    div_zero_o = (rs2_i == '0);
    overflow_o = is_signed && (rs1_i == MIN_NEG) && (rs2_i == '1);
  end

endmodule

// File: rtl/div_sequencer.sv
// Radix-2 restoring divide sequencer for DIV/DIVU/REM/REMU, one quotient bit
// per cycle. Define DIV_FAST_SPECIAL_EN to retire div-by-zero/overflow in one cycle.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  div_sequencer_if.slave  io
);

  localparam int              CNT_W    = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  ONE      = XLEN'(1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] v);
    return ~v + ONE;
  endfunction

  function automatic logic [XLEN-1:0] special_result(
    input logic            is_rem,
    input logic            div_zero,
    input logic [XLEN-1:0] rs1
  );
    if (div_zero) return is_rem ? rs1 : '1;
    return is_rem ? '0 : MIN_NEG;
  endfunction

  // Special cases override whatever the unsigned iteration left behind.
  function automatic logic [XLEN-1:0] fixup(
    input logic [XLEN-1:0] quo,
    input logic [XLEN-1:0] rem,
    input logic            is_rem,
    input logic            neg_quo,
    input logic            neg_rem,
    input logic            div_zero,
    input logic            overflow,
    input logic [XLEN-1:0] rs1
  );
    if (div_zero || overflow) return special_result(is_rem, div_zero, rs1);
    if (is_rem) return neg_rem ? neg2c(rem) : rem;
    return neg_quo ? neg2c(quo) : quo;
  endfunction

  logic            p_is_rem, p_neg_quo, p_neg_rem, p_div_zero, p_overflow;
  logic [XLEN-1:0] p_dvd_mag, p_dvs_mag;

  div_operand_prep #(.XLEN(XLEN)) u_prep (
    .funct3_i   (io.funct3_i),
    .rs1_i      (io.rs1_i),
    .rs2_i      (io.rs2_i),
    .is_rem_o   (p_is_rem),
    .dvd_mag_o  (p_dvd_mag),
    .dvs_mag_o  (p_dvs_mag),
    .neg_quo_o  (p_neg_quo),
    .neg_rem_o  (p_neg_rem),
    .div_zero_o (p_div_zero),
    .overflow_o (p_overflow)
  );

  div_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            div_zero_q, div_zero_d;
  logic            overflow_q, overflow_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;
  logic            accept;

  // One restoring step: shift {rem, quo} left, keep the difference if it fits.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (!trial[XLEN]) begin
      rem_step = trial[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_step = shifted[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  assign accept = io.start_i && !io.kill_i && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    rs1_d      = rs1_q;
    is_rem_d   = is_rem_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    overflow_d = overflow_q;
    result_d   = result_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          rem_d      = '0;
          quo_d      = p_dvd_mag;
          dvs_d      = p_dvs_mag;
          rs1_d      = io.rs1_i;
          is_rem_d   = p_is_rem;
          neg_quo_d  = p_neg_quo;
          neg_rem_d  = p_neg_rem;
          div_zero_d = p_div_zero;
          overflow_d = p_overflow;
          cnt_d      = CNT_LAST;
          state_d    = CALC;
`ifdef DIV_FAST_SPECIAL_EN
          if (p_div_zero || p_overflow) begin
            state_d  = DONE;
            result_d = special_result(p_is_rem, p_div_zero, io.rs1_i);
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = fixup(quo_step, rem_step, is_rem_q, neg_quo_q, neg_rem_q,
                           div_zero_q, overflow_q, rs1_q);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A flush wins over everything, including a result about to be written.
    if (io.kill_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      rs1_q      <= '0;
      is_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      rs1_q      <= rs1_d;
      is_rem_q   <= is_rem_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      overflow_q <= overflow_d;
      result_q   <= result_d;
    end
  end

  assign io.busy_o   = (state_q == CALC);
  assign io.valid_o  = (state_q == DONE);
  assign io.result_o = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed testbench for div_sequencer: hand-computed results and latencies.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;
`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = XLEN + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  div_sequencer_if #(.XLEN(XLEN)) dif ();

  div_sequencer #(.XLEN(XLEN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .io    (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at the negedge of cycle T; returns at a negedge with the DUT idle.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int          seen_at;
    int          pulses;
    logic        busy_first;
    logic [31:0] res;
    seen_at    = -1;
    pulses     = 0;
    busy_first = 1'b0;
    res        = 'x;
    dif.start_i  = 1'b1;
    dif.funct3_i = f3;
    dif.rs1_i    = a;
    dif.rs2_i    = b;
    @(negedge clk);
    dif.start_i = 1'b0;
    dif.rs1_i   = ~a;
    dif.rs2_i   = 32'h0000_1234;
    for (int n = 1; n <= LAT + 3; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 1) busy_first = dif.busy_o;
      if (dif.valid_o) begin
        pulses++;
        if (seen_at < 0) begin
          seen_at = n;
          res     = dif.result_o;
        end
      end
    end
    check({tag, " latency"}, 32'(seen_at), 32'(exp_lat));
    check({tag, " result"}, res, exp_res);
    check({tag, " pulses"}, 32'(pulses), 32'd1);
    check({tag, " busy@T+1"}, 32'(busy_first), 32'(exp_lat > 1));
    check({tag, " held"}, dif.result_o, exp_res);
  endtask

  initial begin
    int          v1_at, v2_at, pulses;
    logic [31:0] v1_res, v2_res;

    dif.start_i  = 1'b0;
    dif.kill_i   = 1'b0;
    dif.funct3_i = 3'b000;
    dif.rs1_i    = '0;
    dif.rs2_i    = '0;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(dif.busy_o), 32'd0);
    check("rst valid", 32'(dif.valid_o), 32'd0);
    check("rst result", dif.result_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("divu 100/7", FUNCT3_DIVU, 32'd100, 32'd7, 32'd14, LAT);
    run_op("remu 100/7", FUNCT3_REMU, 32'd100, 32'd7, 32'd2, LAT);
    run_op("rem -7/2",   FUNCT3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT);
    run_op("div -7/2",   FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT);
    run_op("div -20/-3", FUNCT3_DIV, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'd6, LAT);
    run_op("rem -20/-3", FUNCT3_REM, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, LAT);
    run_op("div 20/-3",  FUNCT3_DIV, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, LAT);
    run_op("divu max/1", FUNCT3_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT);
    run_op("remu max/16", FUNCT3_REMU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, LAT);
    run_op("code000 100/7", 3'b000, 32'd100, 32'd7, 32'd14, LAT);
    run_op("div 5/0",    FUNCT3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    run_op("rem 5/0",    FUNCT3_REM, 32'd5, 32'd0, 32'd5, SPEC_LAT);
    run_op("div -5/0",   FUNCT3_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    run_op("rem -5/0",   FUNCT3_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPEC_LAT);
    run_op("divu 5/0",   FUNCT3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    run_op("div ovf",    FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);
    run_op("rem ovf",    FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPEC_LAT);
    run_op("divu min/-1", FUNCT3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT);

    // Kill at T+10: abort, no valid, previous result (0 from "divu min/-1") kept.
    dif.start_i  = 1'b1;
    dif.funct3_i = FUNCT3_DIVU;
    dif.rs1_i    = 32'd1000;
    dif.rs2_i    = 32'd10;
    @(negedge clk);
    dif.start_i = 1'b0;
    pulses = 0;
    for (int n = 2; n <= 10; n++) begin
      @(negedge clk);
      if (dif.valid_o) pulses++;
    end
    dif.kill_i = 1'b1;
    @(negedge clk);
    dif.kill_i = 1'b0;
    check("kill busy@T+11", 32'(dif.busy_o), 32'd0);
    check("kill valid@T+11", 32'(dif.valid_o), 32'd0);
    check("kill result held", dif.result_o, 32'd0);
    check("kill no pulse", 32'(pulses), 32'd0);

    // start together with kill is refused
    dif.start_i = 1'b1;
    dif.kill_i  = 1'b1;
    @(negedge clk);
    dif.start_i = 1'b0;
    dif.kill_i  = 1'b0;
    check("kill>start busy", 32'(dif.busy_o), 32'd0);
    check("kill>start valid", 32'(dif.valid_o), 32'd0);
    run_op("after kill", FUNCT3_DIVU, 32'd1000, 32'd10, 32'd100, LAT);

    // Back-to-back with start held high; junk operands during CALC are ignored.
    v1_at = -1; v2_at = -1; v1_res = 'x; v2_res = 'x; pulses = 0;
    dif.start_i  = 1'b1;
    dif.funct3_i = FUNCT3_DIVU;
    dif.rs1_i    = 32'd9;
    dif.rs2_i    = 32'd3;
    for (int n = 1; n <= 2 * LAT + 2; n++) begin
      @(negedge clk);
      if (dif.valid_o) begin
        pulses++;
        if (v1_at < 0) begin
          v1_at  = n;
          v1_res = dif.result_o;
        end else if (v2_at < 0) begin
          v2_at  = n;
          v2_res = dif.result_o;
        end
      end
      if (n == 1) begin
        dif.funct3_i = FUNCT3_REM;
        dif.rs1_i    = 32'hDEAD_BEEF;
        dif.rs2_i    = 32'd5;
      end
      if (n == LAT) begin
        dif.funct3_i = FUNCT3_DIVU;
        dif.rs1_i    = 32'd8;
        dif.rs2_i    = 32'd2;
      end
      if (n == 2 * LAT) dif.start_i = 1'b0;
    end
    check("b2b first at", 32'(v1_at), 32'(LAT));
    check("b2b first res", v1_res, 32'd3);
    check("b2b second at", 32'(v2_at), 32'(2 * LAT));
    check("b2b second res", v2_res, 32'd4);
    check("b2b pulses", 32'(pulses), 32'd2);
    check("b2b idle busy", 32'(dif.busy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller for RV32M division (DIV, DIVU, REM, REMU). It sequences a radix-2 restoring divide datapath one quotient bit per cycle and applies the RISC-V sign and special-case rules. It sits beside the single-cycle ALU in the execute stage, and its `busy_o` drives the pipeline stall logic. It accepts one operation at a time through a start/valid handshake and honours pipeline flushes.

## Interface
- `XLEN`, default 32: operand and result width. Iteration count equals `XLEN`.
- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_i`  input  1  reset, asynchronous, active-high.
- `start_i`  input  1  request a new divide; sampled only in IDLE or DONE.
- `funct3_i`  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU. Other codes are treated as DIVU.
- `rs1_i`  input  XLEN  dividend.
- `rs2_i`  input  XLEN  divisor.
- `kill_i`  input  1  flush; aborts any operation in progress.
- `busy_o`  output  1  high while iterating; the pipeline stalls on it.
- `valid_o`  output  1  one-cycle pulse: `result_o` is valid.
- `result_o`  output  XLEN  quotient or remainder; held until the next accepted start.

## Operation
- **States:**
  - IDLE: waits for a start.
  - CALC: `XLEN` iterations.
  - DONE: one cycle; `valid_o` is high.
- **Start:** a start is accepted when `start_i` is high in IDLE or DONE and `kill_i` is low.
  - On acceptance, latch `funct3_i`, the signs, `|rs1_i|` and `|rs2_i|`.
  - Magnitudes are absolute values for DIV/REM and raw values for DIVU/REMU.
  - Set the iteration counter to `XLEN`-1 and go to CALC.
- **CALC iteration:** each cycle, shift {rem, quo} left by 1 and trial-subtract the divisor from rem.
  - If the result is non-negative, keep the difference and set quo bit 0.
  - When the counter reaches 0, go to DONE.
- **DONE fix-up:** the result register is written on the CALC→DONE edge.
  - Quotient is negated if signed and the operand signs differ.
  - Remainder takes the sign of the dividend if signed.
- **Divide by zero:**
  - Quotient = all ones.
  - Remainder = `rs1_i` unmodified.
- **Signed overflow** (DIV/REM with `rs1_i` = 0x80000000 and `rs2_i` = 0xFFFFFFFF):
  - Quotient = 0x80000000.
  - Remainder = 0.
- **Width rules:** rem is `XLEN`+1 bits for the trial subtract. Negation is two's complement, modulo 2^`XLEN`.
- **Priority:** `kill_i` > `start_i`.
  - `kill_i` in any state moves to IDLE on the next edge.
  - The aborted operation produces no `valid_o`.
  - `result_o` keeps its previous value.
- **`start_i` while in CALC:** ignored, with no effect on the operation in progress.
- **`start_i` in DONE:** accepted, which gives back-to-back operation. The next state is CALC, or DONE via the fast path.
- **Reset:** state IDLE, counter 0, `busy_o` 0, `valid_o` 0, `result_o` 0, all latched operands 0.
  - A reset mid-operation discards it with no `valid_o`.

## Timing
- Let T be the cycle in which `start_i` is high and accepted.
- **Normal path:**
  - `busy_o` is high in cycles T+1 … T+`XLEN`.
  - `valid_o` is high in cycle T+`XLEN`+1, which is cycle T+33 for `XLEN`=32.
- **`busy_o` and `valid_o`:** both are decoded from registered state. No combinational path from any input.
- **`result_o`:** registered; it changes only on the edge entering DONE.
- **Throughput:** one result per `XLEN`+1 cycles when `start_i` is held high.

## Configuration
- **Macro `DIV_FAST_SPECIAL_EN` defined:**
  - Divide by zero and signed overflow are detected at acceptance.
  - The special-case result is written directly and the state goes IDLE/DONE→DONE.
  - `valid_o` is high at T+1; `busy_o` stays low.
- **Macro not defined:**
  - Special cases run the full `XLEN` iterations.
  - The DONE fix-up forces the same architectural results.
  - `valid_o` is high at T+`XLEN`+1.
- Results are identical in both builds; only latency differs.

## Structure
- **Shared package:**
  - `FUNCT3_DIV`, `FUNCT3_DIVU`, `FUNCT3_REM`, `FUNCT3_REMU` constants.
  - `div_state_t` enum (IDLE, CALC, DONE).
- **One sub-module, `div_operand_prep`:** combinational.
  - Produces magnitudes, sign flags, and div-by-zero/overflow flags from `funct3_i`, `rs1_i` and `rs2_i`.
- FSM, counter, iteration datapath and fix-up live in `div_sequencer`.

## Test plan
- DIVU 100/7 → `result_o`=14, `valid_o` at T+33; REMU 100/7 → 2.
- REM 0xFFFFFFF9 (-7) by 2 → 0xFFFFFFFF (-1); DIV same operands → 0xFFFFFFFD (-3).
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5.
  - With `DIV_FAST_SPECIAL_EN`, `valid_o` at T+1; without it, at T+33.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
- `kill_i` at T+10 → no `valid_o`, `busy_o` low from T+11, `result_o` unchanged; new start at T+12 completes normally.
- `start_i` held high with DIVU 9/3 then 8/2 → `valid_o` at T+33 (3) and T+66 (4); `start_i` during CALC is ignored.
